// File: rtl/wb_select_pipe.sv
// Registered write-back select: one of NUM_SRC sources becomes the register-file write, with a
// variable-latency load path (MEM_SRC) that waits for mem_valid_i, times out, and can be flushed.
module wb_select_pipe #(
    parameter int              WIDTH   = 32,
    parameter int              NUM_SRC = 4,
    parameter int              MEM_SRC = 2,
    parameter int              TIMEOUT = 15,
    parameter logic [WIDTH-1:0] POISON = WIDTH'(32'hDEADBEEF),
    localparam int             SEL_W   = $clog2(NUM_SRC)
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     flush_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [SEL_W-1:0]         in_sel_i,
    input  logic [4:0]               in_rd_i,
    input  logic [NUM_SRC*WIDTH-1:0] in_data_i,
    input  logic                     mem_valid_i,
    input  logic [WIDTH-1:0]         mem_data_i,
    output logic                     wb_valid_o,
    output logic                     wb_we_o,
    output logic [4:0]               wb_rd_o,
    output logic [WIDTH-1:0]         wb_data_o,
    output logic                     sel_err_o,
    output logic                     tmo_err_o
);

    typedef enum logic {
        IDLE,
        WAIT_MEM
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [4:0]       rd_q, rd_d;
    logic             wb_valid_q, wb_valid_d;
    logic             wb_we_q, wb_we_d;
    logic [4:0]       wb_rd_q, wb_rd_d;
    logic [WIDTH-1:0] wb_data_q, wb_data_d;
    logic             sel_err_q, sel_err_d;
    logic             tmo_err_q, tmo_err_d;

    logic [WIDTH-1:0] src [NUM_SRC];
    logic             sel_in_range;
    logic             sel_is_mem;
    logic             accept;

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
        assign src[k] = in_data_i[k*WIDTH +: WIDTH];
    end

    // Out-of-range selects only exist when NUM_SRC is not a power of two.
    assign sel_in_range = ({1'b0, in_sel_i} < (SEL_W+1)'(NUM_SRC));
    assign sel_is_mem   = (in_sel_i == SEL_W'(MEM_SRC));
    assign in_ready_o   = (state_q == IDLE);
    assign accept       = in_ready_o && in_valid_i && !flush_i;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rd_d       = rd_q;
        wb_valid_d = 1'b0;
        wb_we_d    = 1'b0;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        sel_err_d  = 1'b0;
        tmo_err_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!sel_in_range) begin
                        wb_valid_d = 1'b1;
                        wb_data_d  = POISON;
                        wb_rd_d    = in_rd_i;
                        sel_err_d  = 1'b1;
                    end else if (sel_is_mem) begin
                        rd_d    = in_rd_i;
                        cnt_d   = 8'd0;
                        state_d = WAIT_MEM;
                    end else begin
                        wb_valid_d = 1'b1;
                        wb_we_d    = |in_rd_i;
                        wb_rd_d    = in_rd_i;
                        wb_data_d  = src[in_sel_i];
                    end
                end
            end
            WAIT_MEM: begin
                // Flush beats a same-cycle load return; a return beats the timeout.
                if (flush_i) begin
                    cnt_d   = 8'd0;
                    state_d = IDLE;
                end else if (mem_valid_i) begin
                    wb_valid_d = 1'b1;
                    wb_we_d    = |rd_q;
                    wb_rd_d    = rd_q;
                    wb_data_d  = mem_data_i;
                    cnt_d      = 8'd0;
                    state_d    = IDLE;
                end else if (cnt_q == 8'(TIMEOUT-1)) begin
                    wb_valid_d = 1'b1;
                    wb_rd_d    = rd_q;
                    wb_data_d  = POISON;
                    tmo_err_d  = 1'b1;
                    cnt_d      = 8'd0;
                    state_d    = IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                cnt_d   = 8'd0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            cnt_q      <= 8'd0;
            rd_q       <= 5'd0;
            wb_valid_q <= 1'b0;
            wb_we_q    <= 1'b0;
            wb_rd_q    <= 5'd0;
            wb_data_q  <= '0;
            sel_err_q  <= 1'b0;
            tmo_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rd_q       <= rd_d;
            wb_valid_q <= wb_valid_d;
            wb_we_q    <= wb_we_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            sel_err_q  <= sel_err_d;
            tmo_err_q  <= tmo_err_d;
        end
    end

    assign wb_valid_o = wb_valid_q;
    assign wb_we_o    = wb_we_q;
    assign wb_rd_o    = wb_rd_q;
    assign wb_data_o  = wb_data_q;
    assign sel_err_o  = sel_err_q;
    assign tmo_err_o  = tmo_err_q;

endmodule

// File: tb/tb_wb_select_pipe.sv
module tb_wb_select_pipe;

    localparam int          TMO    = 15;
    localparam logic [31:0] POISON = 32'hDEADBEEF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush, in_valid, mem_valid;
    logic [1:0]  in_sel;
    logic [4:0]  in_rd;
    logic [127:0] in_data;
    logic [95:0] in_data3;
    logic [31:0] mem_data;

    logic        in_ready, wb_valid, wb_we, sel_err, tmo_err;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        in_ready3, wb_valid3, wb_we3, sel_err3, tmo_err3;
    logic [4:0]  wb_rd3;
    logic [31:0] wb_data3;

    logic [40:0] obs, obs3;
    assign obs  = {wb_valid, wb_we, sel_err, tmo_err, wb_rd, wb_data};
    assign obs3 = {wb_valid3, wb_we3, sel_err3, tmo_err3, wb_rd3, wb_data3};

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    wb_select_pipe dut (
        .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush), .in_valid_i(in_valid),
        .in_ready_o(in_ready), .in_sel_i(in_sel), .in_rd_i(in_rd), .in_data_i(in_data),
        .mem_valid_i(mem_valid), .mem_data_i(mem_data), .wb_valid_o(wb_valid),
        .wb_we_o(wb_we), .wb_rd_o(wb_rd), .wb_data_o(wb_data),
        .sel_err_o(sel_err), .tmo_err_o(tmo_err)
    );

    wb_select_pipe #(.NUM_SRC(3)) dut3 (
        .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush), .in_valid_i(in_valid),
        .in_ready_o(in_ready3), .in_sel_i(in_sel), .in_rd_i(in_rd), .in_data_i(in_data3),
        .mem_valid_i(mem_valid), .mem_data_i(mem_data), .wb_valid_o(wb_valid3),
        .wb_we_o(wb_we3), .wb_rd_o(wb_rd3), .wb_data_o(wb_data3),
        .sel_err_o(sel_err3), .tmo_err_o(tmo_err3)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tests++;
        if (obs !== 41'd0) begin fails++; $display("FAIL reset_outputs: got %h want %h", obs, 41'd0); end
        tests++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", in_ready); end
        tests++;
        if (obs3 !== 41'd0) begin fails++; $display("FAIL reset_outputs3: got %h want %h", obs3, 41'd0); end
    endtask

    task automatic test_alu();
        logic [40:0] exp;
        in_data  = {32'h0000_1234, $urandom, $urandom, $urandom};
        in_sel   = 2'd3;
        in_rd    = 5'd5;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        exp = {4'b1100, 5'd5, 32'h0000_1234};
        tests++;
        if (obs !== exp) begin fails++; $display("FAIL alu_wb: got %h want %h", obs, exp); end
        step();
        exp = {4'b0000, 5'd5, 32'h0000_1234};
        tests++;
        if (obs !== exp) begin fails++; $display("FAIL alu_hold: got %h want %h", obs, exp); end
    endtask

    task automatic test_back_to_back();
        logic [1:0]  sels [4];
        logic [31:0] d;
        logic [40:0] exp;
        sels    = '{2'd0, 2'd1, 2'd3, 2'd0};
        in_data = {$urandom, $urandom, $urandom, $urandom};
        for (int i = 0; i < 4; i++) begin
            in_sel   = sels[i];
            in_rd    = 5'(i + 1);
            in_valid = 1'b1;
            tests++;
            if (in_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready[%0d]: got %b want 1", i, in_ready); end
            step();
            d   = in_data[int'(sels[i])*32 +: 32];
            exp = {4'b1100, 5'(i + 1), d};
            tests++;
            if (obs !== exp) begin fails++; $display("FAIL b2b_wb[%0d]: got %h want %h", i, obs, exp); end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_load();
        int          delays [3];
        logic [4:0]  rds [3];
        logic [31:0] md;
        logic [40:0] exp;
        delays = '{3, 1, TMO};
        rds    = '{5'd7, 5'd0, 5'd19};
        for (int c = 0; c < 3; c++) begin
            md       = (c == 0) ? 32'hCAFE_F00D : $urandom;
            in_sel   = 2'd2;
            in_rd    = rds[c];
            in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            for (int k = 1; k <= delays[c]; k++) begin
                if (k == delays[c]) begin mem_valid = 1'b1; mem_data = md; end
                tests++;
                if (in_ready !== 1'b0) begin fails++; $display("FAIL load_ready_wait[%0d]: got %b want 0", c, in_ready); end
                step();
                mem_valid = 1'b0;
                if (k < delays[c]) begin
                    tests++;
                    if (wb_valid !== 1'b0) begin fails++; $display("FAIL load_early_wb[%0d]: got %b want 0", c, wb_valid); end
                end
            end
            exp = {1'b1, |rds[c], 2'b00, rds[c], md};
            tests++;
            if (obs !== exp) begin fails++; $display("FAIL load_wb[%0d]: got %h want %h", c, obs, exp); end
            tests++;
            if (in_ready !== 1'b1) begin fails++; $display("FAIL load_ready_after[%0d]: got %b want 1", c, in_ready); end
        end
    endtask

    task automatic test_timeout();
        in_sel   = 2'd2;
        in_rd    = 5'd12;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int k = 1; k <= TMO; k++) begin
            tests++;
            if (in_ready !== 1'b0) begin fails++; $display("FAIL tmo_ready[%0d]: got %b want 0", k, in_ready); end
            step();
            if (k < TMO) begin
                tests++;
                if (wb_valid !== 1'b0) begin fails++; $display("FAIL tmo_early_wb[%0d]: got %b want 0", k, wb_valid); end
            end
        end
        tests++;
        if ({obs[40:37], wb_data} !== {4'b1001, POISON})
            begin fails++; $display("FAIL tmo_wb: got %h want %h", {obs[40:37], wb_data}, {4'b1001, POISON}); end
        step();
        tests++;
        if ({wb_valid, tmo_err} !== 2'b00) begin fails++; $display("FAIL tmo_pulse: got %b want 00", {wb_valid, tmo_err}); end
    endtask

    task automatic test_rd_zero();
        logic [40:0] exp;
        in_data  = {$urandom, $urandom, $urandom, $urandom};
        in_sel   = 2'd1;
        in_rd    = 5'd0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        exp = {4'b1000, 5'd0, in_data[63:32]};
        tests++;
        if (obs !== exp) begin fails++; $display("FAIL rd_zero: got %h want %h", obs, exp); end
    endtask

    task automatic test_flush();
        in_sel   = 2'd2;
        in_rd    = 5'd9;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        flush     = 1'b1;
        mem_valid = 1'b1;
        mem_data  = 32'h1111_2222;
        step();
        flush = 1'b0;
        tests++;
        if (wb_valid !== 1'b0) begin fails++; $display("FAIL flush_wait_wb: got %b want 0", wb_valid); end
        tests++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL flush_wait_ready: got %b want 1", in_ready); end
        step();
        mem_valid = 1'b0;
        tests++;
        if (wb_valid !== 1'b0) begin fails++; $display("FAIL idle_mem_ignored: got %b want 0", wb_valid); end
        in_sel   = 2'd0;
        in_valid = 1'b1;
        flush    = 1'b1;
        tests++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL flush_idle_ready: got %b want 1", in_ready); end
        step();
        in_valid = 1'b0;
        flush    = 1'b0;
        tests++;
        if (wb_valid !== 1'b0) begin fails++; $display("FAIL flush_idle_wb: got %b want 0", wb_valid); end
    endtask

    task automatic test_reset_mid_load();
        in_data  = {$urandom, $urandom, $urandom, 32'hA5A5_5A5A};
        in_sel   = 2'd0;
        in_rd    = 5'd4;
        in_valid = 1'b1;
        step();
        in_sel = 2'd2;
        in_rd  = 5'd3;
        step();
        in_valid = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        tests++;
        if (obs !== 41'd0) begin fails++; $display("FAIL rst_mid_outputs: got %h want %h", obs, 41'd0); end
        tests++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_mid_ready: got %b want 1", in_ready); end
        mem_valid = 1'b1;
        mem_data  = 32'h7777_8888;
        step();
        #2 rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step();
            mem_valid = 1'($urandom_range(0, 1));
            tests++;
            if (wb_valid !== 1'b0) begin fails++; $display("FAIL rst_mid_no_wb[%0d]: got %b want 0", k, wb_valid); end
        end
        mem_valid = 1'b0;
    endtask

    task automatic test_sel_err();
        logic [40:0] exp;
        in_data  = {$urandom, $urandom, $urandom, $urandom};
        in_data3 = {$urandom, $urandom, $urandom};
        in_sel   = 2'd3;
        in_rd    = 5'd9;
        in_valid = 1'b1;
        step();
        in_sel = 2'd1;
        in_rd  = 5'd4;
        exp = {4'b1010, 5'd9, POISON};
        tests++;
        if (obs3 !== exp) begin fails++; $display("FAIL sel_err_wb: got %h want %h", obs3, exp); end
        exp = {4'b1100, 5'd9, in_data[127:96]};
        tests++;
        if (obs !== exp) begin fails++; $display("FAIL sel3_legal4: got %h want %h", obs, exp); end
        step();
        in_valid = 1'b0;
        exp = {4'b1100, 5'd4, in_data3[63:32]};
        tests++;
        if (obs3 !== exp) begin fails++; $display("FAIL sel_ok3: got %h want %h", obs3, exp); end
    endtask

    task automatic test_random();
        int          kind, d, lat, idx;
        logic [1:0]  alu_sels [3];
        logic [4:0]  rd;
        logic [31:0] md;
        logic [40:0] exp;
        alu_sels = '{2'd0, 2'd1, 2'd3};
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                mem_valid = 1'($urandom_range(0, 1));
                mem_data  = $urandom;
                step();
                mem_valid = 1'b0;
                tests++;
                if (wb_valid !== 1'b0) begin fails++; $display("FAIL rnd_gap[%0d]: got %b want 0", n, wb_valid); end
            end
            kind     = $urandom_range(0, 2);
            rd       = 5'($urandom);
            in_rd    = rd;
            in_data  = {$urandom, $urandom, $urandom, $urandom};
            in_valid = 1'b1;
            if (kind < 2) begin
                idx    = $urandom_range(0, 2);
                in_sel = alu_sels[idx];
                step();
                in_valid = 1'b0;
                exp = {1'b1, |rd, 2'b00, rd, in_data[int'(alu_sels[idx])*32 +: 32]};
                tests++;
                if (obs !== exp) begin fails++; $display("FAIL rnd_alu[%0d]: got %h want %h", n, obs, exp); end
            end else begin
                in_sel = 2'd2;
                d      = $urandom_range(1, TMO + 3);
                lat    = (d <= TMO) ? d : TMO;
                md     = $urandom;
                step();
                in_valid = 1'b0;
                for (int k = 1; k <= lat; k++) begin
                    if (k == d) begin mem_valid = 1'b1; mem_data = md; end
                    tests++;
                    if (in_ready !== 1'b0) begin fails++; $display("FAIL rnd_ready[%0d]: got %b want 0", n, in_ready); end
                    step();
                    mem_valid = 1'b0;
                    if (k < lat) begin
                        tests++;
                        if (wb_valid !== 1'b0) begin fails++; $display("FAIL rnd_early[%0d]: got %b want 0", n, wb_valid); end
                    end
                end
                if (d <= TMO) begin
                    exp = {1'b1, |rd, 2'b00, rd, md};
                    tests++;
                    if (obs !== exp) begin fails++; $display("FAIL rnd_load[%0d]: got %h want %h", n, obs, exp); end
                end else begin
                    tests++;
                    if ({obs[40:37], wb_data} !== {4'b1001, POISON})
                        begin fails++; $display("FAIL rnd_tmo[%0d]: got %h want %h", n, {obs[40:37], wb_data}, {4'b1001, POISON}); end
                    mem_valid = 1'b1;
                    step();
                    mem_valid = 1'b0;
                    tests++;
                    if (wb_valid !== 1'b0) begin fails++; $display("FAIL rnd_late_mem[%0d]: got %b want 0", n, wb_valid); end
                end
            end
        end
    endtask

    initial begin
        rst_n     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        mem_valid = 1'b0;
        in_sel    = 2'd0;
        in_rd     = 5'd0;
        in_data   = '0;
        in_data3  = '0;
        mem_data  = '0;
        #1 rst_n = 1'b0;
        #2;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        test_alu();
        test_back_to_back();
        test_load();
        test_timeout();
        test_rd_zero();
        test_flush();
        test_reset_mid_load();
        test_sel_err();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout want finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/wb_select_pipe.md
Name: wb_select_pipe

Overview:
- Parametrised, registered successor to the combinational write-back select in the OTTER core.
- Selects one of NUM_SRC write-back sources (PC+4, CSR, load data, ALU, ...) and produces a registered register-file write: data, destination, write enable.
- Adds a variable-latency memory-load path with wait state, timeout, flush and illegal-select detection.
- Sits between the execute/memory stage and the register file write port.

Parameters:
- WIDTH, 32, data width of each source and of the write-back data.
- NUM_SRC, 4, number of selectable sources (2..16).
- SEL_W, $clog2(NUM_SRC), select width (derived, not overridden).
- MEM_SRC, 2, source index that waits for MEM_VALID/MEM_DATA instead of using IN_DATA.
- TIMEOUT, 15, maximum cycles spent in WAIT_MEM (1..255).
- POISON, 32'hDEADBEEF, data driven on any error write-back.

Ports:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- FLUSH  in  1  synchronous abort of pending or accepted instruction.
- IN_VALID  in  1  request valid.
- IN_READY  out  1  request accepted when IN_VALID & IN_READY.
- IN_SEL  in  SEL_W  source index.
- IN_RD  in  5  destination register.
- IN_DATA  in  NUM_SRC*WIDTH  flattened sources; source k is bits [k*WIDTH +: WIDTH].
- MEM_VALID  in  1  load data valid.
- MEM_DATA  in  WIDTH  load data.
- WB_VALID  out  1  one-cycle write-back pulse.
- WB_WE  out  1  register-file write enable.
- WB_RD  out  5  write-back destination.
- WB_DATA  out  WIDTH  write-back data.
- SEL_ERR  out  1  one-cycle pulse on illegal select.
- TMO_ERR  out  1  one-cycle pulse on load timeout.

Behaviour:
- Reset, async assert: state IDLE, counter 0, and every output 0 except IN_READY.
- IN_READY is combinational: 1 in IDLE, 0 in WAIT_MEM.
- FSM has two states, IDLE and WAIT_MEM.
- All WB_* and error outputs are registered. When not written, WB_VALID, WB_WE, SEL_ERR and TMO_ERR are 0. WB_DATA and WB_RD hold their last value.
- IDLE, accept with IN_SEL != MEM_SRC and IN_SEL < NUM_SRC:
  - Next cycle: WB_VALID=1, WB_DATA=source[IN_SEL], WB_RD=IN_RD, WB_WE=(IN_RD!=0).
  - State stays IDLE; back-to-back accepts give one write-back per cycle (latency 1).
- IDLE, accept with IN_SEL >= NUM_SRC (only possible when NUM_SRC is not a power of 2):
  - Next cycle: WB_VALID=1, WB_WE=0, WB_DATA=POISON, WB_RD=IN_RD, SEL_ERR=1.
- IDLE, accept with IN_SEL == MEM_SRC:
  - Capture IN_RD, clear counter, go to WAIT_MEM. No write-back yet.
- MEM_VALID while in IDLE is ignored.
- WAIT_MEM, each cycle:
  - If MEM_VALID: next cycle WB_VALID=1, WB_DATA=MEM_DATA, WB_RD=captured rd, WB_WE=(rd!=0); go to IDLE.
  - Else if counter == TIMEOUT-1: next cycle WB_VALID=1, WB_WE=0, WB_DATA=POISON, TMO_ERR=1; go to IDLE.
  - Else counter+1.
  - MEM_VALID in the final counted cycle wins over timeout.
  - Minimum load latency is 2 cycles from accept to WB_VALID.
- FLUSH has highest priority:
  - In IDLE: suppresses acceptance that cycle. No write-back results, but IN_READY is still 1.
  - In WAIT_MEM: return to IDLE, no write-back, counter cleared. A MEM_VALID in the same cycle is dropped.
- Write-back data is never modified for rd=0; only WB_WE is forced 0.
- Async reset mid-WAIT_MEM discards the pending load; no write-back is produced after reset release.

Test Plan:
- Reset, then accept IN_SEL=3 (ALU=32'h0000_1234), IN_RD=5 -> next cycle WB_VALID=1, WB_WE=1, WB_RD=5, WB_DATA=32'h0000_1234.
- Four back-to-back accepts, IN_SEL 0,1,3,0, rd 1..4 -> four consecutive WB_VALID pulses with matching data and rd; IN_READY=1 throughout.
- IN_SEL=2, IN_RD=7, MEM_VALID 3 cycles later with MEM_DATA=32'hCAFE_F00D -> IN_READY=0 while waiting; WB_DATA=32'hCAFE_F00D, WB_RD=7 one cycle after MEM_VALID.
- IN_SEL=2 with no MEM_VALID -> WB_VALID=1, WB_WE=0, WB_DATA=32'hDEADBEEF, TMO_ERR=1 exactly 16 cycles after accept.
- IN_SEL=1, IN_RD=0 -> WB_VALID=1, WB_WE=0, data passed.
- FLUSH in 2nd WAIT_MEM cycle, then MEM_VALID -> no write-back, IN_READY=1 next cycle.
- RST_N low mid-load -> all outputs 0 immediately; no write-back after release.
- NUM_SRC=3 build, IN_SEL=3 -> SEL_ERR=1, WB_DATA=POISON, WB_WE=0.
